// File: rtl/riscv_dram_pkg.sv
// Shared definitions for the DRAM latency controller: state encoding,
// default latency/refresh constants and small elaboration-time helpers.
package riscv_dram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_READY   = 2'd2,
    ST_REFRESH = 2'd3
  } dram_state_e;

  localparam int unsigned DEF_RD_LAT         = 4;
  localparam int unsigned DEF_WR_LAT         = 4;
  localparam int unsigned DEF_REFRESH_PERIOD = 0;
  localparam int unsigned DEF_REFRESH_CYCLES = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold 0..m-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned m);
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/riscv_dram_refresh_timer.sv
// Free-running refresh timer with a single-entry pending flag. A further
// expiry while a refresh is already pending is absorbed, not queued.
module riscv_dram_refresh_timer
  import riscv_dram_pkg::*;
#(
  parameter int unsigned PERIOD = DEF_REFRESH_PERIOD
)(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic pending
);

  generate
    if (PERIOD == 0) begin : g_off
      // Refresh disabled: no state, pending never rises.
      logic unused_in;
      assign unused_in = ^{clk, rst, clear};
      assign pending   = 1'b0;
    end else begin : g_on
      localparam int unsigned TMR_W = cnt_width(PERIOD);

      logic [TMR_W-1:0] tmr_q, tmr_d;
      logic             pending_q, pending_d;
      logic             expire;

      // Wrap the timer every PERIOD cycles; an expiry arriving on the clear
      // edge still registers so that period is not lost.
      always_comb begin
        expire    = (tmr_q == TMR_W'(PERIOD - 1));
        tmr_d     = expire ? '0 : tmr_q + 1'b1;
        pending_d = pending_q;
        if (clear)  pending_d = 1'b0;
        if (expire) pending_d = 1'b1;
      end

      // Timer and pending flag registers.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          tmr_q     <= '0;
          pending_q <= 1'b0;
        end else begin
          tmr_q     <= tmr_d;
          pending_q <= pending_d;
        end
      end

      assign pending = pending_q;
    end
  endgenerate

endmodule

// File: rtl/riscv_dram_latency_ctrl.sv
// Fixed-latency DRAM access model: holds the requester for RD_LAT/WR_LAT
// cycles, returns a one-cycle mem_ready pulse, and slots periodic refresh
// stalls in between accesses.
module riscv_dram_latency_ctrl
  import riscv_dram_pkg::*;
#(
  parameter int unsigned RD_LAT         = DEF_RD_LAT,
  parameter int unsigned WR_LAT         = DEF_WR_LAT,
  parameter int unsigned REFRESH_PERIOD = DEF_REFRESH_PERIOD,
  parameter int unsigned REFRESH_CYCLES = DEF_REFRESH_CYCLES
)(
  input  logic clk,
  input  logic rst,
  input  logic wren,
  input  logic rden,
  output logic mem_ready,
  output logic mem_busy,
  output logic refresh_active
);

  localparam int unsigned CNT_W = cnt_width(max3(RD_LAT, WR_LAT, REFRESH_CYCLES));

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t RD_LOAD  = cnt_t'(RD_LAT - 1);
  localparam cnt_t WR_LOAD  = cnt_t'(WR_LAT - 1);
  localparam cnt_t REF_LOAD = cnt_t'(REFRESH_CYCLES - 1);

  dram_state_e state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic        mem_ready_q, mem_ready_d;
  logic        ref_pending;
  logic        ref_clear;

  riscv_dram_refresh_timer #(
    .PERIOD (REFRESH_PERIOD)
  ) u_refresh_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (ref_clear),
    .pending (ref_pending)
  );

  // Next-state logic. The latency of the accepted op is captured in the
  // counter at sampling time, so later changes of wren/rden cannot alter
  // it; only dropping both aborts. LAT=1 loads 0 and spends a single cycle
  // in ACCESS, which keeps ready at edge k+LAT for every latency.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ref_pending) begin
          state_d   = ST_REFRESH;
          cnt_d     = REF_LOAD;
          ref_clear = 1'b1;
        end else if (wren) begin
          state_d = ST_ACCESS;
          cnt_d   = WR_LOAD;
        end else if (rden) begin
          state_d = ST_ACCESS;
          cnt_d   = RD_LOAD;
        end
      end
      ST_ACCESS: begin
        if (!(wren || rden)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_READY: begin
        state_d = ST_IDLE;
      end
      ST_REFRESH: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    mem_ready_d = (state_d == ST_READY);
  end

  // State, counter and ready-pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  assign mem_ready      = mem_ready_q;
  assign mem_busy       = (state_q != ST_IDLE);
  assign refresh_active = (state_q == ST_REFRESH);

endmodule

// File: tb/tb_riscv_dram_latency_ctrl.sv
// Bench for riscv_dram_latency_ctrl: four parameterisations driven in
// parallel; expected mem_ready cycles are queued as requests are issued and
// a monitor pops and compares them whenever a DUT pulses mem_ready.
module tb_riscv_dram_latency_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc;
  int   n_chk  = 0;
  int   n_pass = 0;

  logic wr_def = 0, rd_def = 0, rdy_def, busy_def, ref_def;
  logic wr_rw  = 0, rd_rw  = 0, rdy_rw,  busy_rw,  ref_rw;
  logic wr_ref = 0, rd_ref = 0, rdy_ref, busy_ref, ref_ref;
  logic wr_l1  = 0, rd_l1  = 0, rdy_l1,  busy_l1,  ref_l1;

  int q_def[$], q_rw[$], q_ref[$], q_l1[$];

  always #5 clk = ~clk;

  // Cycle n is the period following the n-th rising edge after reset release.
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  riscv_dram_latency_ctrl u_def (
    .clk(clk), .rst(rst), .wren(wr_def), .rden(rd_def),
    .mem_ready(rdy_def), .mem_busy(busy_def), .refresh_active(ref_def));

  riscv_dram_latency_ctrl #(.RD_LAT(2), .WR_LAT(6)) u_rw (
    .clk(clk), .rst(rst), .wren(wr_rw), .rden(rd_rw),
    .mem_ready(rdy_rw), .mem_busy(busy_rw), .refresh_active(ref_rw));

  riscv_dram_latency_ctrl #(.REFRESH_PERIOD(20), .REFRESH_CYCLES(8)) u_ref (
    .clk(clk), .rst(rst), .wren(wr_ref), .rden(rd_ref),
    .mem_ready(rdy_ref), .mem_busy(busy_ref), .refresh_active(ref_ref));

  riscv_dram_latency_ctrl #(.RD_LAT(1), .WR_LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .wren(wr_l1), .rden(rd_l1),
    .mem_ready(rdy_l1), .mem_busy(busy_l1), .refresh_active(ref_l1));

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard pop for one DUT that just presented mem_ready.
  task automatic sb_pop(input int id);
    int exp;
    bit empty;
    exp   = -1;
    empty = 1'b0;
    case (id)
      0: if (q_def.size() == 0) empty = 1; else exp = q_def.pop_front();
      1: if (q_rw.size()  == 0) empty = 1; else exp = q_rw.pop_front();
      2: if (q_ref.size() == 0) empty = 1; else exp = q_ref.pop_front();
      default: if (q_l1.size() == 0) empty = 1; else exp = q_l1.pop_front();
    endcase
    n_chk++;
    if (empty)
      $display("FAIL unexpected_ready dut%0d: mem_ready at cycle %0d, none expected", id, cyc);
    else if (exp != cyc)
      $display("FAIL ready_cycle dut%0d: mem_ready at cycle %0d expected cycle %0d", id, cyc, exp);
    else
      n_pass++;
  endtask

  // Monitor: sample outputs mid-cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rdy_def) sb_pop(0);
      if (rdy_rw)  sb_pop(1);
      if (rdy_ref) sb_pop(2);
      if (rdy_l1)  sb_pop(3);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy_def",  busy_def, 1'b0);
    chk("rst_ready_def", rdy_def,  1'b0);
    chk("rst_ref_ref",   ref_ref,  1'b0);
    chk("rst_busy_ref",  busy_ref, 1'b0);

    // Release reset with requests already held ("cycle 0").
    rst    = 1'b1;
    rd_def = 1'b1;  q_def.push_back(5);
    wr_rw  = 1'b1;  rd_rw = 1'b1;  q_rw.push_back(7);
    rd_l1  = 1'b1;  q_l1.push_back(2);  q_l1.push_back(5);  q_l1.push_back(8);

    fork
      begin : b_def
        chk("def_busy_c0", busy_def, 1'b0);
        for (int c = 1; c <= 5; c++) begin
          wait_cyc(c);
          chk("def_busy_access", busy_def, 1'b1);
        end
        rd_def = 1'b0;
        wait_cyc(6);
        chk("def_busy_idle", busy_def, 1'b0);
        rd_def = 1'b1;                 // sampled at edge 7, aborted later
        wait_cyc(9);
        rd_def = 1'b0;
        chk("abort_busy_c9", busy_def, 1'b1);
        wait_cyc(10);
        chk("abort_busy_c10", busy_def, 1'b0);
        wait_cyc(12);
        chk("abort_idle_c12", busy_def, 1'b0);
      end
      begin : b_rw
        wait_cyc(6);
        chk("rw_busy_c6", busy_rw, 1'b1);
        wait_cyc(7);
        wr_rw = 1'b0;                  // keep rden: new read after one IDLE
        q_rw.push_back(11);
        wait_cyc(8);
        chk("rw_idle_gap", busy_rw, 1'b0);
        wait_cyc(9);
        chk("rw_busy_c9", busy_rw, 1'b1);
        wait_cyc(11);
        rd_rw = 1'b0;
      end
      begin : b_ref
        wait_cyc(17);
        rd_ref = 1'b1;
        q_ref.push_back(22);
        wait_cyc(20);
        chk("ref_no_preempt_c20", ref_ref, 1'b0);
        chk("ref_busy_c20", busy_ref, 1'b1);
        wait_cyc(21);
        chk("ref_no_preempt_c21", ref_ref, 1'b0);
        wait_cyc(22);
        rd_ref = 1'b0;
        wait_cyc(23);
        chk("ref_idle_c23", ref_ref, 1'b0);
        chk("ref_busy_c23", busy_ref, 1'b0);
        for (int c = 24; c <= 31; c++) begin
          wait_cyc(c);
          chk("ref_active", ref_ref, 1'b1);
          if (c == 26) begin
            rd_ref = 1'b1;
            q_ref.push_back(37);
          end
        end
        wait_cyc(32);
        chk("ref_end_c32", ref_ref, 1'b0);
        chk("ref_idle_c32", busy_ref, 1'b0);
        wait_cyc(37);
        rd_ref = 1'b0;
      end
      begin : b_l1
        wait_cyc(3);
        chk("l1_idle_c3", busy_l1, 1'b0);
        wait_cyc(4);
        chk("l1_busy_c4", busy_l1, 1'b1);
        wait_cyc(8);
        rd_l1 = 1'b0;
      end
    join

    // Reset in the middle of an access on the default instance.
    wait_cyc(50);
    rd_def = 1'b1;                     // sampled at edge 51
    wait_cyc(52);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_busy",  busy_def, 1'b0);
    chk("async_rst_ready", rdy_def,  1'b0);
    chk("async_rst_ref",   ref_def,  1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("held_rst_busy", busy_def, 1'b0);
    q_def.push_back(5);
    rst = 1'b1;                        // request still held: re-issued
    wait_cyc(1);
    chk("post_rst_busy_c1", busy_def, 1'b1);
    wait_cyc(5);
    rd_def = 1'b0;
    wait_cyc(8);

    chk_int("pending_def", q_def.size(), 0);
    chk_int("pending_rw",  q_rw.size(),  0);
    chk_int("pending_ref", q_ref.size(), 0);
    chk_int("pending_l1",  q_l1.size(),  0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
